// File: rtl/blake2_pkg.sv
// rtl/blake2_pkg.sv - shared state encoding and constants for the blake2 message feeder
// Purpose: state encoding, default word/block sizes and the pad byte used by blake2_msg_pad.
// Ports: none (package).
package blake2_pkg;

  localparam int W_DEFAULT  = 64;
  localparam int BB_DEFAULT = 2 * W_DEFAULT;

  localparam logic [7:0] PAD_BYTE = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DATA     = 3'd1,
    S_PAD      = 3'd2,
    S_WAIT_F   = 3'd3,
    S_WAIT_RDY = 3'd4
  } state_e;

endpackage

// File: rtl/blake2_msg_pad.sv
// rtl/blake2_msg_pad.sv - splits a host byte stream into zero-padded blake2 blocks
// Purpose: accepts host bytes with an end-of-message marker, issues them to the
//   compression core one byte per cycle with their block index, zero-pads the
//   final block and counts the message length.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_v_i/in_data_i           host byte valid / byte
//   in_last_i/in_empty_i       final transfer / final transfer carries no byte
//   in_ready_o                 host transfer accepted when in_v_i & in_ready_o
//   core_ready_i               core ready (low while compressing)
//   data_v_o/data_idx_o/data_o byte pulse, index within block, byte value
//   block_first_o/block_last_o block position flags for the issued byte
//   ll_o                       total message length in bytes
module blake2_msg_pad
  import blake2_pkg::*;
#(
  parameter int W        = W_DEFAULT,
  parameter int BB       = 2 * W,
  parameter int BB_CLOG2 = $clog2(BB),
  parameter int LL_W     = 2 * W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_v_i,
  input  logic [7:0]          in_data_i,
  input  logic                in_last_i,
  input  logic                in_empty_i,
  output logic                in_ready_o,
  input  logic                core_ready_i,
  output logic                data_v_o,
  output logic [BB_CLOG2-1:0] data_idx_o,
  output logic [7:0]          data_o,
  output logic                block_first_o,
  output logic                block_last_o,
  output logic [LL_W-1:0]     ll_o
);

  localparam logic [BB_CLOG2-1:0] IDX_LAST = BB_CLOG2'(BB - 1);

  state_e              state_q, state_d;
  logic [BB_CLOG2-1:0] idx_q, idx_d;
  logic [LL_W-1:0]     ll_q, ll_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic                data_v_q, data_v_d;
  logic [BB_CLOG2-1:0] data_idx_q, data_idx_d;
  logic [7:0]          data_q, data_d;
  logic                blk_first_q, blk_first_d;
  logic                blk_last_q, blk_last_d;

  logic                accept;
  logic [BB_CLOG2-1:0] idx_cur;
  logic [LL_W-1:0]     ll_cur;
  logic                first_cur;

  // Accepting a host byte and issuing it to the core happen in the same cycle,
  // so the host is only ready when the core is.
  assign in_ready_o = ((state_q == S_IDLE) || (state_q == S_DATA)) & core_ready_i & ~reset;
  assign accept     = in_v_i & in_ready_o;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ll_d        = ll_q;
    first_d     = first_q;
    last_d      = last_q;
    data_v_d    = 1'b0;
    data_idx_d  = data_idx_q;
    data_d      = data_q;
    blk_first_d = blk_first_q;
    blk_last_d  = blk_last_q;

    // The first accept of a message starts from idx 0, zero length, first block;
    // ll is only cleared here so it stays readable after the previous message.
    idx_cur   = (state_q == S_IDLE) ? '0   : idx_q;
    ll_cur    = (state_q == S_IDLE) ? '0   : ll_q;
    first_cur = (state_q == S_IDLE) ? 1'b1 : first_q;

    case (state_q)
      S_IDLE, S_DATA: begin
        if (accept) begin
          idx_d   = idx_cur;
          ll_d    = ll_cur;
          first_d = first_cur;
          last_d  = 1'b0;
          if (in_last_i && in_empty_i) begin
            // No byte on this transfer: the rest of the block is all padding.
            last_d  = 1'b1;
            state_d = S_PAD;
          end else begin
            data_v_d    = 1'b1;
            data_idx_d  = idx_cur;
            data_d      = in_data_i;
            blk_first_d = first_cur;
            blk_last_d  = in_last_i;
            ll_d        = ll_cur + LL_W'(1);
            idx_d       = idx_cur + BB_CLOG2'(1);
            if (in_last_i) begin
              last_d  = 1'b1;
              state_d = (idx_cur == IDX_LAST) ? S_WAIT_F : S_PAD;
            end else if (idx_cur == IDX_LAST) begin
              first_d = 1'b0;
              state_d = S_WAIT_F;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_PAD: begin
        if (core_ready_i) begin
          data_v_d    = 1'b1;
          data_idx_d  = idx_q;
          data_d      = PAD_BYTE;
          blk_first_d = first_q;
          blk_last_d  = 1'b1;
          idx_d       = idx_q + BB_CLOG2'(1);
          if (idx_q == IDX_LAST) begin
            state_d = S_WAIT_F;
          end
        end
      end

      // The core drops ready once it has taken the block into compression.
      S_WAIT_F: begin
        if (!core_ready_i) begin
          state_d = S_WAIT_RDY;
        end
      end

      S_WAIT_RDY: begin
        if (core_ready_i) begin
          state_d = last_q ? S_IDLE : S_DATA;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ll_q        <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      data_v_q    <= 1'b0;
      data_idx_q  <= '0;
      data_q      <= '0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ll_q        <= ll_d;
      first_q     <= first_d;
      last_q      <= last_d;
      data_v_q    <= data_v_d;
      data_idx_q  <= data_idx_d;
      data_q      <= data_d;
      blk_first_q <= blk_first_d;
      blk_last_q  <= blk_last_d;
    end
  end

  assign data_v_o      = data_v_q;
  assign data_idx_o    = data_idx_q;
  assign data_o        = data_q;
  assign block_first_o = blk_first_q;
  assign block_last_o  = blk_last_q;
  assign ll_o          = ll_q;

endmodule

// File: tb/tb_blake2_msg_pad.sv
// tb/tb_blake2_msg_pad.sv - self-checking bench for blake2_msg_pad
module tb_blake2_msg_pad;

  localparam int W    = 64;
  localparam int BB   = 128;
  localparam int BI   = 7;
  localparam int LL_W = 128;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_v_i;
  logic [7:0]      in_data_i;
  logic            in_last_i;
  logic            in_empty_i;
  logic            in_ready_o;
  logic            core_ready_i;
  logic            data_v_o;
  logic [BI-1:0]   data_idx_o;
  logic [7:0]      data_o;
  logic            block_first_o;
  logic            block_last_o;
  logic [LL_W-1:0] ll_o;

  blake2_msg_pad #(.W(W), .BB(BB), .BB_CLOG2(BI), .LL_W(LL_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_v_i        (in_v_i),
    .in_data_i     (in_data_i),
    .in_last_i     (in_last_i),
    .in_empty_i    (in_empty_i),
    .in_ready_o    (in_ready_o),
    .core_ready_i  (core_ready_i),
    .data_v_o      (data_v_o),
    .data_idx_o    (data_idx_o),
    .data_o        (data_o),
    .block_first_o (block_first_o),
    .block_last_o  (block_last_o),
    .ll_o          (ll_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  msg[$];
  logic [16:0] obs[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: byte i of the padded stream for an n-byte message.
  function automatic logic [16:0] exp_entry(input int i, input int n);
    logic [7:0] d;
    logic       f;
    logic       l;
    d = (i < n) ? msg[i] : 8'h00;
    f = (i < BB);
    l = (i >= n - 1);
    return {f, l, 7'(i % BB), d};
  endfunction

  task automatic fill_rand(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  task automatic run_msg(input int stall_idx, input int reset_idx, input string tag);
    int n, total, sent, cyc, comp_left, stall_left;
    bit sent_last, fin_low, done, ready_prev, stall_prev, stall_done, bad_issue;
    n = msg.size();
    total = ((n == 0) ? 1 : (n + BB - 1) / BB) * BB;
    obs.delete();
    sent = 0; cyc = 0; comp_left = 0; stall_left = 0;
    sent_last = 0; fin_low = 0; done = 0; stall_prev = 0; stall_done = 0; bad_issue = 0;
    ready_prev = core_ready_i;
    while (!done && cyc < 6000) begin
      ready_prev = core_ready_i;
      if (stall_prev) chk({tag, "_stall_no_issue"}, data_v_o, 0);
      stall_prev = 0;
      if (data_v_o) begin
        obs.push_back({block_first_o, block_last_o, data_idx_o, data_o});
        if (!ready_prev) bad_issue = 1;
      end
      if (reset_idx >= 0 && data_v_o && block_last_o && int'(data_idx_o) == reset_idx) begin
        core_ready_i = 1'b1;
        in_v_i = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk({tag, "_rst_data_v"}, data_v_o, 0);
        chk({tag, "_rst_idx"}, data_idx_o, 0);
        chk({tag, "_rst_first"}, block_first_o, 0);
        chk({tag, "_rst_last"}, block_last_o, 0);
        chk({tag, "_rst_ll"}, ll_o, 0);
        chk({tag, "_rst_in_ready"}, in_ready_o, 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (fin_low && ready_prev) begin
        done = 1;
        break;
      end
      // Core model: compress after every full block, plus random and directed stalls.
      if (data_v_o && int'(data_idx_o) == BB - 1) comp_left = 1 + $urandom_range(0, 3);
      if (stall_idx >= 0 && !stall_done && data_v_o && int'(data_idx_o) == stall_idx) begin
        stall_left = 5;
        stall_done = 1;
      end
      if (comp_left > 0) begin
        core_ready_i = 1'b0;
        comp_left--;
        if (obs.size() == total) fin_low = 1;
      end else if (stall_left > 0) begin
        core_ready_i = 1'b0;
        stall_left--;
        stall_prev = 1;
      end else begin
        core_ready_i = ($urandom_range(0, 9) != 0);
      end
      in_v_i     = !sent_last && ($urandom_range(0, 3) != 0);
      in_data_i  = (sent < n) ? msg[sent] : 8'h00;
      in_last_i  = (n == 0) || (sent == n - 1);
      in_empty_i = (n == 0);
      #1;
      if (stall_prev) chk({tag, "_stall_in_ready"}, in_ready_o, 0);
      if (in_v_i && in_ready_o) begin
        if (n == 0) sent_last = 1;
        else begin
          sent++;
          if (sent == n) sent_last = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_v_i = 1'b0;
    core_ready_i = 1'b1;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_count"}, obs.size(), total);
    for (int i = 0; i < obs.size() && i < total; i++)
      chk($sformatf("%s_b%0d", tag, i), obs[i], exp_entry(i, n));
    chk({tag, "_ll"}, ll_o, n);
    chk({tag, "_no_issue_when_busy"}, bad_issue, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, "_idle_quiet"}, data_v_o, 0);
    end
    chk({tag, "_ll_held"}, ll_o, n);
  endtask

  initial begin
    reset = 1'b1;
    in_v_i = 1'b0; in_data_i = 8'h00; in_last_i = 1'b0; in_empty_i = 1'b0;
    core_ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("in_ready_in_reset", in_ready_o, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_data_v", data_v_o, 0);
    chk("reset_idx", data_idx_o, 0);
    chk("reset_data", data_o, 0);
    chk("reset_first", block_first_o, 0);
    chk("reset_last", block_last_o, 0);
    chk("reset_ll", ll_o, 0);
    chk("idle_in_ready", in_ready_o, 1);

    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg(-1, -1, "abc");

    fill_rand(128);
    run_msg(-1, -1, "len128");

    fill_rand(129);
    run_msg(-1, -1, "len129");

    msg.delete();
    run_msg(-1, -1, "empty");

    fill_rand(200);
    run_msg(40, -1, "stall40");

    fill_rand(5);
    run_msg(-1, 90, "reset_pad");

    fill_rand(70);
    run_msg(-1, -1, "after_reset");

    for (int k = 0; k < 3; k++) begin
      fill_rand($urandom_range(1, 300));
      run_msg(-1, -1, $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
